// File: rtl/ahb_resp_pkg.sv
// Shared types and constants for the AHB-lite SRAM responder.
//   word_t        32-bit bus/memory word
//   resp_state_t  responder FSM state (IDLE, DATA)
//   WORD_BYTES    bytes per memory word (sets the byte-to-word address shift)
//   MAX_WAIT      largest supported wait-state count
//   clampWait()   saturates a requested wait-state count to MAX_WAIT
package ahb_resp_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, DATA} resp_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned MAX_WAIT   = 15;
  localparam int unsigned CNT_BITS   = $clog2(MAX_WAIT + 1);

  function automatic logic [CNT_BITS-1:0] clampWait(int unsigned ws);
    return (ws > MAX_WAIT) ? CNT_BITS'(MAX_WAIT) : CNT_BITS'(ws);
  endfunction

endpackage

// File: rtl/ahb_seq_prefetch_buf.sv
// One-entry sequential prefetch buffer: holds a word index (tag), its data and a valid bit.
// Only instantiated when AHB_SEQ_PREFETCH_EN is defined.
// Ports:
//   clk, rstN             clock, asynchronous active-low reset
//   fill/fillTag/fillData load a new entry (marks it valid)
//   invalidate/invalTag   drop the entry if the committed write hits its tag
//   lookupTag/hit/data    combinational lookup of the held entry
module ahb_seq_prefetch_buf
  import ahb_resp_pkg::*;
#(
  parameter int unsigned TAG_BITS = 10
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                fill,
  input  logic [TAG_BITS-1:0] fillTag,
  input  word_t               fillData,
  input  logic                invalidate,
  input  logic [TAG_BITS-1:0] invalTag,
  input  logic [TAG_BITS-1:0] lookupTag,
  output logic                hit,
  output word_t               data
);

  logic                validQ;
  logic [TAG_BITS-1:0] tagQ;
  word_t               dataQ;

  // Fill and invalidate never coincide: fills happen on a read's completing edge,
  // invalidates on a write's completing edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      validQ <= 1'b0;
      tagQ   <= '0;
      dataQ  <= '0;
    end else if (fill) begin
      validQ <= 1'b1;
      tagQ   <= fillTag;
      dataQ  <= fillData;
    end else if (invalidate && (invalTag == tagQ)) begin
      validQ <= 1'b0;
    end
  end

  assign hit  = validQ && (lookupTag == tagQ);
  assign data = dataQ;

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-lite word memory responder with a programmable number of HREADY-low wait states.
// Optional feature macro: AHB_SEQ_PREFETCH_EN (adds a one-entry next-word read prefetch).
// Ports:
//   HCLK, HRESETn   clock (rising edge), asynchronous active-low reset
//   HADDR           byte address; word index taken from HADDR[ADDR_BITS+1:2], upper bits alias
//   HWRITE          1 = write, 0 = read; sampled with the address phase
//   HREQUEST        address-phase valid
//   HWDATA          write data, sampled on the completing edge of a write data phase
//   HRDATA          registered read data, valid while HREADY=1 in a read data phase
//   HREADY          1 = data phase completes this cycle (or bus idle)
module ahb_sram_responder
  import ahb_resp_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic        HREQUEST,
  input  word_t       HWDATA,
  output word_t       HRDATA,
  output logic        HREADY
);

  localparam int unsigned ADDR_BITS = $clog2(MEM_WORDS);
  localparam int unsigned ADDR_LSB  = $clog2(WORD_BYTES);
  localparam logic [CNT_BITS-1:0] WAIT_LOAD = clampWait(WAIT_STATES);

  typedef logic [ADDR_BITS-1:0] idx_t;

  word_t mem [MEM_WORDS];

  resp_state_t         stateQ, stateD;
  logic [CNT_BITS-1:0] cntQ, cntD;
  idx_t                addrQ, addrD;
  logic                writeQ, writeD;
  word_t               rdataQ, rdataD;

  idx_t                reqIdx;
  logic                accept, complete, wrCommit;
  logic                pfHit;
  word_t               pfData;
  logic [CNT_BITS-1:0] loadCnt;
  logic                unusedAddrBits;

  assign reqIdx         = HADDR[ADDR_BITS+ADDR_LSB-1:ADDR_LSB];
  assign unusedAddrBits = ^{HADDR[31:ADDR_BITS+ADDR_LSB], HADDR[ADDR_LSB-1:0]};

  assign HREADY   = (stateQ == IDLE) || (cntQ == '0);
  assign accept   = HREQUEST && HREADY;
  assign complete = (stateQ == DATA) && (cntQ == '0);
  assign wrCommit = complete && writeQ;
  assign loadCnt  = pfHit ? '0 : WAIT_LOAD;
  assign HRDATA   = rdataQ;

`ifdef AHB_SEQ_PREFETCH_EN
  logic bufHit;
  idx_t nextIdx;

  // Wraps naturally at the top of the array.
  assign nextIdx = addrQ + idx_t'(1);

  ahb_seq_prefetch_buf #(
    .TAG_BITS (ADDR_BITS)
  ) uPrefetch (
    .clk        (HCLK),
    .rstN       (HRESETn),
    .fill       (complete && !writeQ),
    .fillTag    (nextIdx),
    .fillData   (mem[nextIdx]),
    .invalidate (wrCommit),
    .invalTag   (addrQ),
    .lookupTag  (reqIdx),
    .hit        (bufHit),
    .data       (pfData)
  );

  assign pfHit = bufHit && !HWRITE;
`else
  assign pfHit  = 1'b0;
  assign pfData = '0;
`endif

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    addrD  = addrQ;
    writeD = writeQ;
    rdataD = rdataQ;
    if ((stateQ == DATA) && (cntQ != '0)) begin
      cntD = cntQ - CNT_BITS'(1);
      // Load read data one edge early so it is registered in the HREADY=1 cycle.
      if ((cntQ == CNT_BITS'(1)) && !writeQ) begin
        rdataD = mem[addrQ];
      end
    end else if (accept) begin
      stateD = DATA;
      addrD  = reqIdx;
      writeD = HWRITE;
      cntD   = loadCnt;
      // Zero-wait read: data must be ready the very next cycle. Forward a write
      // committing on this same edge to the same word.
      if (!HWRITE && (loadCnt == '0)) begin
        if (wrCommit && (addrQ == reqIdx)) begin
          rdataD = HWDATA;
        end else if (pfHit) begin
          rdataD = pfData;
        end else begin
          rdataD = mem[reqIdx];
        end
      end
    end else begin
      stateD = IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      addrQ  <= '0;
      writeQ <= 1'b0;
      rdataQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      addrQ  <= addrD;
      writeQ <= writeD;
      rdataQ <= rdataD;
    end
  end

  // Array has no reset; a reset aborts the transfer before wrCommit can fire.
  always_ff @(posedge HCLK) begin
    if (wrCommit) begin
      mem[addrQ] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_sram_responder.sv
module tb_ahb_sram_responder;

  localparam int MEMW = 1024;
  localparam int WS_A = 2;
  localparam int WS_C = 3;
`ifdef AHB_SEQ_PREFETCH_EN
  localparam int NI = 3;
`else
  localparam int NI = 2;
`endif

  logic        clk;
  logic        rstN;
  logic        hreq   [NI];
  logic        hwrite [NI];
  logic [31:0] haddr  [NI];
  logic [31:0] hwdata [NI];
  logic [31:0] hrdata [NI];
  logic        hready [NI];

  logic [31:0] expQ [$];
  int          checks;
  int          passes;

  ahb_sram_responder #(.MEM_WORDS(MEMW), .WAIT_STATES(WS_A)) uDutA (
    .HCLK(clk), .HRESETn(rstN), .HADDR(haddr[0]), .HWRITE(hwrite[0]), .HREQUEST(hreq[0]),
    .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0])
  );

  ahb_sram_responder #(.MEM_WORDS(MEMW), .WAIT_STATES(0)) uDutB (
    .HCLK(clk), .HRESETn(rstN), .HADDR(haddr[1]), .HWRITE(hwrite[1]), .HREQUEST(hreq[1]),
    .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1])
  );

`ifdef AHB_SEQ_PREFETCH_EN
  ahb_sram_responder #(.MEM_WORDS(MEMW), .WAIT_STATES(WS_C)) uDutC (
    .HCLK(clk), .HRESETn(rstN), .HADDR(haddr[2]), .HWRITE(hwrite[2]), .HREQUEST(hreq[2]),
    .HWDATA(hwdata[2]), .HRDATA(hrdata[2]), .HREADY(hready[2])
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One non-pipelined transfer on instance d; starts and ends 1 time unit after a rising edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output int waits, output logic [31:0] rdata);
    hreq[d]   = 1'b1;
    hwrite[d] = wr;
    haddr[d]  = addr;
    @(posedge clk); #1;
    hreq[d]   = 1'b0;
    hwdata[d] = wdata;
    waits = 0;
    while (!hready[d] && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    rdata = hrdata[d];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < NI; d++) begin
      checks++;
      if (hready[d] !== 1'b1) $display("FAIL reset_hready[%0d]: got %b want 1", d, hready[d]);
      else passes++;
      checks++;
      if (hrdata[d] !== 32'h0) $display("FAIL reset_hrdata[%0d]: got %h want 0", d, hrdata[d]);
      else passes++;
    end
  endtask

  task automatic test_write_read();
    int w;
    logic [31:0] r, e;
    xfer(0, 1'b1, 32'h40, 32'hDEADBEEF, w, r);
    checks++;
    if (w !== WS_A) $display("FAIL wr_waits: got %0d want %0d", w, WS_A);
    else passes++;
    expQ.push_back(32'hDEADBEEF);
    xfer(0, 1'b0, 32'h40, 32'h0, w, r);
    checks++;
    if (w !== WS_A) $display("FAIL rd_waits: got %0d want %0d", w, WS_A);
    else passes++;
    e = expQ.pop_front();
    checks++;
    if (r !== e) $display("FAIL rd_data: got %h want %h", r, e);
    else passes++;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (hrdata[0] !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", hrdata[0]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        hreq[1] = 1'b1; hwrite[1] = 1'b1; haddr[1] = 32'(i * 4);
      end else begin
        hreq[1] = 1'b0;
      end
      if (i > 0) hwdata[1] = 32'hB0B0_0000 | 32'(i - 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      hreq[1] = 1'b1; hwrite[1] = 1'b0; haddr[1] = 32'(i * 4);
      expQ.push_back(32'hB0B0_0000 | 32'(i));
      @(posedge clk); #1;
      checks++;
      if (hready[1] !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, hready[1]);
      else passes++;
      e = expQ.pop_front();
      checks++;
      if (hrdata[1] !== e) $display("FAIL b2b_data[%0d]: got %h want %h", i, hrdata[1], e);
      else passes++;
    end
    hreq[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_raw();
    int w, ws;
    logic [31:0] r, e, v;
    for (int d = 0; d < 2; d++) begin
      ws = (d == 0) ? WS_A : 0;
      v  = (d == 0) ? 32'h11 : 32'h22;
      xfer(d, 1'b1, 32'h80, 32'h55, w, r);
      hreq[d] = 1'b1; hwrite[d] = 1'b1; haddr[d] = 32'h80;
      @(posedge clk); #1;
      hreq[d] = 1'b0; hwdata[d] = v;
      w = 0;
      while (!hready[d] && w < 40) begin @(posedge clk); #1; w++; end
      // Read accepted on the write's completing edge.
      hreq[d] = 1'b1; hwrite[d] = 1'b0; haddr[d] = 32'h80;
      expQ.push_back(v);
      @(posedge clk); #1;
      hreq[d] = 1'b0;
      w = 0;
      while (!hready[d] && w < 40) begin @(posedge clk); #1; w++; end
      checks++;
      if (w !== ws) $display("FAIL raw_waits[%0d]: got %0d want %0d", d, w, ws);
      else passes++;
      e = expQ.pop_front();
      checks++;
      if (hrdata[d] !== e) $display("FAIL raw_data[%0d]: got %h want %h", d, hrdata[d], e);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alias();
    int w;
    logic [31:0] r, e;
    xfer(0, 1'b1, 32'h8, 32'h0A11_A5ED, w, r);
    expQ.push_back(32'h0A11_A5ED);
    xfer(0, 1'b0, 32'(MEMW * 4 + 8), 32'h0, w, r);
    e = expQ.pop_front();
    checks++;
    if (r !== e) $display("FAIL alias_hi_read: got %h want %h", r, e);
    else passes++;
    xfer(0, 1'b1, 32'(MEMW * 4 + 8), 32'h5EED_0008, w, r);
    expQ.push_back(32'h5EED_0008);
    xfer(0, 1'b0, 32'h8, 32'h0, w, r);
    e = expQ.pop_front();
    checks++;
    if (r !== e) $display("FAIL alias_lo_read: got %h want %h", r, e);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int w;
    logic [31:0] r, e;
    xfer(0, 1'b1, 32'h200, 32'hCAFE_0001, w, r);
    hreq[0] = 1'b1; hwrite[0] = 1'b1; haddr[0] = 32'h200;
    @(posedge clk); #1;
    hreq[0] = 1'b0; hwdata[0] = 32'h0BAD_F00D;
    checks++;
    if (hready[0] !== 1'b0) $display("FAIL rst_mid_wait: got %b want 0", hready[0]);
    else passes++;
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (hready[0] !== 1'b1) $display("FAIL rst_async_hready: got %b want 1", hready[0]);
    else passes++;
    checks++;
    if (hrdata[0] !== 32'h0) $display("FAIL rst_async_hrdata: got %h want 0", hrdata[0]);
    else passes++;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;
    expQ.push_back(32'hCAFE_0001);
    xfer(0, 1'b0, 32'h200, 32'h0, w, r);
    e = expQ.pop_front();
    checks++;
    if (r !== e) $display("FAIL rst_mem_kept: got %h want %h", r, e);
    else passes++;
  endtask

`ifdef AHB_SEQ_PREFETCH_EN
  task automatic test_prefetch();
    int w;
    logic [31:0] r, e;
    xfer(2, 1'b1, 32'h100, 32'h1000_0100, w, r);
    xfer(2, 1'b1, 32'h104, 32'h1000_0104, w, r);
    for (int pass = 0; pass < 2; pass++) begin
      expQ.push_back(32'h1000_0100);
      xfer(2, 1'b0, 32'h100, 32'h0, w, r);
      e = expQ.pop_front();
      checks++;
      if (w !== WS_C) $display("FAIL pf_first_waits[%0d]: got %0d want %0d", pass, w, WS_C);
      else passes++;
      checks++;
      if (r !== e) $display("FAIL pf_first_data[%0d]: got %h want %h", pass, r, e);
      else passes++;
      repeat (4) begin @(posedge clk); #1; end
      if (pass == 1) xfer(2, 1'b1, 32'h104, 32'h2000_0104, w, r);
      expQ.push_back((pass == 0) ? 32'h1000_0104 : 32'h2000_0104);
      xfer(2, 1'b0, 32'h104, 32'h0, w, r);
      e = expQ.pop_front();
      checks++;
      if (w !== ((pass == 0) ? 0 : WS_C))
        $display("FAIL pf_next_waits[%0d]: got %0d want %0d", pass, w,
                 (pass == 0) ? 0 : WS_C);
      else passes++;
      checks++;
      if (r !== e) $display("FAIL pf_next_data[%0d]: got %h want %h", pass, r, e);
      else passes++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    rstN   = 1'b0;
    for (int d = 0; d < NI; d++) begin
      hreq[d] = 1'b0; hwrite[d] = 1'b0; haddr[d] = 32'h0; hwdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_write_read();
    test_back_to_back();
    test_raw();
    test_alias();
    test_reset_mid();
`ifdef AHB_SEQ_PREFETCH_EN
    test_prefetch();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
